// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the uart_rx serial receiver.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } state_e;

    // 100 MHz system clock / 230400 baud
    localparam int DEFAULT_CLKS_PER_BIT = 434;
    localparam int DATA_BITS            = 8;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line; resets to the
// idle (high) level so a reset never looks like a start edge.
module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Two-stage capture of the line into the clk domain
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first, centre-of-bit sampling by oversampling
// with the system clock. Define UART_RX_SYNC_EN to insert a 2-flop
// synchronizer on rx_serial (adds 2 clk to all detection/sampling).
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_serial,
    output logic [7:0] dout
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       IDX_LAST  = 3'(DATA_BITS - 1);

    logic rx_s;

`ifdef UART_RX_SYNC_EN
    uart_rx_sync u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (rx_serial),
        .q_o (rx_s)
    );
`else
    assign rx_s = rx_serial;
`endif

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [2:0]             idx_q, idx_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic [DATA_BITS-1:0]   dout_q, dout_d;

    // State, counters and data registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            dout_q  <= dout_d;
        end
    end

    // Next-state logic: the counter restarts from 0 on every state change
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        idx_d   = idx_q;
        shift_d = shift_q;
        dout_d  = dout_q;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                // Strict compare: an unknown line level never starts a frame
                if (rx_s == 1'b0) begin
                    state_d = START;
                end
            end

            START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    idx_d = '0;
                    if (rx_s == 1'b0) begin
                        state_d = DATA;
                    end else begin
                        // Start bit gone by mid-bit: treat as a glitch
                        state_d = IDLE;
                    end
                end
            end

            DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                    if (idx_q == IDX_LAST) begin
                        dout_d  = {rx_s, shift_q[DATA_BITS-1:1]};
                        state_d = STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end

            STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    if (rx_s == 1'b1) begin
                        state_d = IDLE;
                    end else begin
                        // Framing error or break: hold off until the line idles
                        state_d = WAIT_IDLE;
                    end
                end
            end

            WAIT_IDLE: begin
                cnt_d = '0;
                if (rx_s == 1'b1) begin
                    state_d = IDLE;
                end
            end

            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    assign dout = dout_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx with default parameters.
`timescale 1ns/1ps
module tb_uart_rx;
    import uart_rx_pkg::*;

    localparam int BIT  = 4330;
    localparam int HALF = 2160;

    logic       clk;
    logic       rst;
    logic       rx_serial;
    logic [7:0] dout;

    int n_cmp;
    int n_bad;

    uart_rx dut (
        .clk       (clk),
        .rst       (rst),
        .rx_serial (rx_serial),
        .dout      (dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive_frame(input logic [7:0] b);
        rx_serial = 1'b0;
        #BIT;
        for (int i = 0; i < 8; i++) begin
            rx_serial = b[i];
            #BIT;
        end
    endtask

    task automatic test_reset;
        rx_serial = 1'bx;
        rst = 1'b1;
        #50;
        @(negedge clk);
        rx_serial = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #200;
        n_cmp++;
        if (dout !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_dout: got %h want 00", dout);
        end
        n_cmp++;
        if (dut.state_q !== IDLE) begin
            n_bad++;
            $display("FAIL reset_state: got %0d want %0d", dut.state_q, IDLE);
        end
    endtask

    task automatic test_frame;
        logic [7:0] b;
        b = 8'hC1;
        @(negedge clk);
        rx_serial = 1'b0;
        #BIT;
        for (int i = 0; i < 7; i++) begin
            rx_serial = b[i];
            #BIT;
        end
        rx_serial = b[7];
        #1000;
        n_cmp++;
        if (dout !== 8'h00) begin
            n_bad++;
            $display("FAIL frame_early: got %h want 00", dout);
        end
        #(BIT - 1000);
        rx_serial = 1'b1;
        #1000;
        n_cmp++;
        if (dout !== 8'hC1) begin
            n_bad++;
            $display("FAIL frame_c1: got %h want c1", dout);
        end
        #(BIT - 1000);
        #BIT;
    endtask

    task automatic test_glitch;
        @(negedge clk);
        rx_serial = 1'b0;
        #1000;
        rx_serial = 1'b1;
        #3000;
        n_cmp++;
        if (dut.state_q !== IDLE) begin
            n_bad++;
            $display("FAIL glitch_state: got %0d want %0d", dut.state_q, IDLE);
        end
        n_cmp++;
        if (dout !== 8'hC1) begin
            n_bad++;
            $display("FAIL glitch_dout: got %h want c1", dout);
        end
        #BIT;
        drive_frame(8'h5A);
        rx_serial = 1'b1;
        #HALF;
        n_cmp++;
        if (dout !== 8'h5A) begin
            n_bad++;
            $display("FAIL glitch_5a: got %h want 5a", dout);
        end
        #(BIT - HALF);
        #BIT;
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        drive_frame(8'hA5);
        rx_serial = 1'b1;
        #HALF;
        n_cmp++;
        if (dout !== 8'hA5) begin
            n_bad++;
            $display("FAIL b2b_a5: got %h want a5", dout);
        end
        #(BIT - HALF);
        drive_frame(8'h3C);
        rx_serial = 1'b1;
        #HALF;
        n_cmp++;
        if (dout !== 8'h3C) begin
            n_bad++;
            $display("FAIL b2b_3c: got %h want 3c", dout);
        end
        #(BIT - HALF);
        #BIT;
    endtask

    task automatic test_framing_error;
        @(negedge clk);
        drive_frame(8'hFF);
        rx_serial = 1'b0;
        #(BIT + HALF);
        n_cmp++;
        if (dout !== 8'hFF) begin
            n_bad++;
            $display("FAIL ferr_dout: got %h want ff", dout);
        end
        #(2 * BIT - HALF);
        n_cmp++;
        if (dut.state_q !== WAIT_IDLE) begin
            n_bad++;
            $display("FAIL ferr_state: got %0d want %0d", dut.state_q, WAIT_IDLE);
        end
        rx_serial = 1'b1;
        #(2 * BIT);
        drive_frame(8'h12);
        rx_serial = 1'b1;
        #HALF;
        n_cmp++;
        if (dout !== 8'h12) begin
            n_bad++;
            $display("FAIL ferr_12: got %h want 12", dout);
        end
        #(BIT - HALF);
        #BIT;
    endtask

    task automatic test_reset_mid_frame;
        logic [7:0] b;
        b = 8'h77;
        @(negedge clk);
        rx_serial = 1'b0;
        #BIT;
        for (int i = 0; i < 3; i++) begin
            rx_serial = b[i];
            #BIT;
        end
        rx_serial = b[3];
        #HALF;
        rst = 1'b1;
        #100;
        n_cmp++;
        if (dout !== 8'h00) begin
            n_bad++;
            $display("FAIL rstmid_dout: got %h want 00", dout);
        end
        n_cmp++;
        if (dut.state_q !== IDLE) begin
            n_bad++;
            $display("FAIL rstmid_state: got %0d want %0d", dut.state_q, IDLE);
        end
        #(BIT - HALF - 100);
        for (int i = 4; i < 8; i++) begin
            rx_serial = b[i];
            #BIT;
        end
        rx_serial = 1'b1;
        #BIT;
        rst = 1'b0;
        #BIT;
        drive_frame(8'h81);
        rx_serial = 1'b1;
        #HALF;
        n_cmp++;
        if (dout !== 8'h81) begin
            n_bad++;
            $display("FAIL rstmid_81: got %h want 81", dout);
        end
        #(BIT - HALF);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b1;
        rx_serial = 1'b1;
        test_reset();
        test_frame();
        test_glitch();
        test_back_to_back();
        test_framing_error();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
